usb_tx_encoder: RTL and testbench

USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

---
 rtl/usb_pkg.sv | 31 +++
 rtl/usb_tx_encoder_if.sv | 29 ++
 rtl/usb_tx_bit_timer.sv | 34 +++
 rtl/usb_tx_encoder.sv | 189 ++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_pkg
// Purpose  : Shared types and constants for the USB full-speed transmit encoder.
// Revision : 1.0 - initial release
// ============================================================================
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DATA     = 3'd1,
    STUFF    = 3'd2,
    EOP_SE0A = 3'd3,
    EOP_SE0B = 3'd4,
    EOP_J    = 3'd5
  } tx_state_t;

  // Line pairs are packed as {d_plus, d_minus}.
  localparam logic [1:0] c_line_j   = 2'b10;
  localparam logic [1:0] c_line_k   = 2'b01;
  localparam logic [1:0] c_line_se0 = 2'b00;

  localparam int c_stuff_threshold = 6;

  // NRZI: a 1 holds the line, a 0 swaps J and K.
  function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
    return bit_val ? line : ~line;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_encoder_if
// Purpose  : Shift-register handshake and line-drive bundle of the TX encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface usb_tx_encoder_if;

  logic tx_enable;
  logic tx_out;
  logic eop_req;
  logic tx_shift;
  logic d_plus;
  logic d_minus;
  logic tx_busy;
  logic eop_done;

  modport master (
    output tx_enable, tx_out, eop_req,
    input  tx_shift, d_plus, d_minus, tx_busy, eop_done
  );

  modport slave (
    input  tx_enable, tx_out, eop_req,
    output tx_shift, d_plus, d_minus, tx_busy, eop_done
  );

endinterface
`default_nettype wire

// File: rtl/usb_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_bit_timer
// Purpose  : Bit-period counter; strobes boundary on the last cycle of a bit.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic boundary
);

  localparam int                c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear || (r_count == c_last)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign boundary = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_encoder
// Purpose  : USB full-speed NRZI line encoder with bit stuffing and EOP.
//            Define USB_TX_BITSTUFF_EN to enable bit stuffing.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_encoder
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  usb_tx_encoder_if.slave   bus
);

  tx_state_t  r_state;
  tx_state_t  w_next_state;
  logic [1:0] r_line;
  logic [1:0] w_line_next;
  logic       r_eop_done;
  logic       w_done_next;
  logic       w_shift;
  logic       w_boundary;
  logic       w_timer_clear;

`ifdef USB_TX_BITSTUFF_EN
  localparam logic [2:0] c_ones_last = 3'(c_stuff_threshold - 1);

  logic [2:0] r_ones;
  logic [2:0] w_ones_next;
  logic       r_eop_pend;
  logic       w_eop_pend_next;
`endif

  // Holding the timer cleared through IDLE starts DATA at count 0.
  assign w_timer_clear = (r_state == IDLE);

  usb_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (w_timer_clear),
    .boundary (w_boundary)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_line     <= c_line_j;
      r_eop_done <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_line     <= w_line_next;
      r_eop_done <= w_done_next;
    end
  end

`ifdef USB_TX_BITSTUFF_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ones     <= '0;
      r_eop_pend <= 1'b0;
    end else begin
      r_ones     <= w_ones_next;
      r_eop_pend <= w_eop_pend_next;
    end
  end
`endif

  always_comb begin
    w_next_state = r_state;
    w_line_next  = r_line;
    w_shift      = 1'b0;
    w_done_next  = 1'b0;
`ifdef USB_TX_BITSTUFF_EN
    w_ones_next     = r_ones;
    w_eop_pend_next = r_eop_pend;
`endif

    case (r_state)
      IDLE: begin
        w_line_next = c_line_j;
`ifdef USB_TX_BITSTUFF_EN
        w_ones_next     = '0;
        w_eop_pend_next = 1'b0;
`endif
        if (bus.tx_enable) begin
          w_next_state = DATA;
        end
      end

      DATA: begin
        if (!bus.tx_enable) begin
          w_next_state = IDLE;
          w_line_next  = c_line_j;
`ifdef USB_TX_BITSTUFF_EN
          w_ones_next     = '0;
          w_eop_pend_next = 1'b0;
`endif
        end else if (w_boundary) begin
          w_shift     = 1'b1;
          w_line_next = nrzi_next(r_line, bus.tx_out);
`ifdef USB_TX_BITSTUFF_EN
          if (!bus.tx_out) begin
            w_ones_next = '0;
            if (bus.eop_req) begin
              w_next_state = EOP_SE0A;
            end
          end else if (r_ones == c_ones_last) begin
            // Sixth consecutive one: a stuff bit must precede anything else.
            w_ones_next     = r_ones + 3'd1;
            w_eop_pend_next = bus.eop_req;
            w_next_state    = STUFF;
          end else begin
            w_ones_next = r_ones + 3'd1;
            if (bus.eop_req) begin
              w_next_state = EOP_SE0A;
            end
          end
`else
          if (bus.eop_req) begin
            w_next_state = EOP_SE0A;
          end
`endif
        end
      end

      STUFF: begin
        if (!bus.tx_enable) begin
          w_next_state = IDLE;
          w_line_next  = c_line_j;
`ifdef USB_TX_BITSTUFF_EN
          w_ones_next     = '0;
          w_eop_pend_next = 1'b0;
`endif
        end else if (w_boundary) begin
          w_line_next  = ~r_line;
          w_next_state = DATA;
`ifdef USB_TX_BITSTUFF_EN
          w_ones_next     = '0;
          w_eop_pend_next = 1'b0;
          if (r_eop_pend) begin
            w_next_state = EOP_SE0A;
          end
`endif
        end
      end

      // The EOP runs to completion even if tx_enable falls.
      EOP_SE0A: begin
        if (w_boundary) begin
          w_line_next  = c_line_se0;
          w_next_state = EOP_SE0B;
        end
      end

      EOP_SE0B: begin
        if (w_boundary) begin
          w_line_next  = c_line_se0;
          w_next_state = EOP_J;
        end
      end

      EOP_J: begin
        if (w_boundary) begin
          w_line_next  = c_line_j;
          w_next_state = IDLE;
          w_done_next  = 1'b1;
        end
      end

      default: begin
        w_next_state = IDLE;
        w_line_next  = c_line_j;
      end
    endcase
  end

  assign bus.tx_shift = w_shift;
  assign bus.d_plus   = r_line[1];
  assign bus.d_minus  = r_line[0];
  assign bus.tx_busy  = (r_state != IDLE);
  assign bus.eop_done = r_eop_done;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_tx_encoder
// Purpose  : Directed self-checking bench for usb_tx_encoder (CLKS_PER_BIT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_encoder;

  localparam int         CPB     = 4;
  localparam int         LOG_LEN = 100;
  localparam logic [1:0] LJ      = 2'b10;
  localparam logic [1:0] LK      = 2'b01;
  localparam logic [1:0] LSE0    = 2'b00;

  logic clk = 1'b0;
  logic n_rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Per-cycle capture; index 0 is the cycle before the IDLE->DATA edge.
  logic [1:0] line_log  [LOG_LEN];
  logic       shift_log [LOG_LEN];
  logic       busy_log  [LOG_LEN];
  int         done_idx;
  int         shift_cnt;

  usb_tx_encoder_if bus ();

  usb_tx_encoder #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Models the transmit shift register: advances one bit per tx_shift strobe.
  task automatic run_packet(input logic [31:0] bits, input int nbits, input bit last_eop,
                            input int drop_after);
    int   idx;
    logic sh;
    for (int i = 0; i < LOG_LEN; i++) begin
      line_log[i]  = 2'bxx;
      shift_log[i] = 1'bx;
      busy_log[i]  = 1'bx;
    end
    done_idx  = -1;
    shift_cnt = 0;
    idx       = 0;
    @(posedge clk); #1;
    bus.tx_enable = 1'b1;
    bus.tx_out    = bits[0];
    bus.eop_req   = last_eop && (nbits == 1);
    for (int c = 0; c < LOG_LEN; c++) begin
      @(negedge clk);
      line_log[c]  = {bus.d_plus, bus.d_minus};
      shift_log[c] = bus.tx_shift;
      busy_log[c]  = bus.tx_busy;
      if (bus.tx_shift) shift_cnt++;
      if (bus.eop_done) begin
        done_idx = c;
        break;
      end
      sh = bus.tx_shift;
      @(posedge clk); #1;
      if (c == drop_after) bus.tx_enable = 1'b0;
      if (sh) begin
        idx++;
        bus.tx_out  = (idx < nbits) ? bits[idx[4:0]] : 1'b0;
        bus.eop_req = last_eop && (idx == nbits - 1);
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.tx_enable = 1'b0;
    bus.tx_out    = 1'b0;
    bus.eop_req   = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.d_plus, bus.d_minus, bus.tx_shift, bus.tx_busy, bus.eop_done} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 10000",
               {bus.d_plus, bus.d_minus, bus.tx_shift, bus.tx_busy, bus.eop_done});
    end
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.d_plus, bus.d_minus, bus.tx_busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got %b expected 100", {bus.d_plus, bus.d_minus, bus.tx_busy});
    end
  endtask

  task automatic test_byte_0x80();
    logic [1:0] exp_bit [8];
    logic       exp_sh;
    exp_bit = '{LK, LJ, LK, LJ, LK, LJ, LK, LK};
    run_packet(32'h80, 8, 1'b1, -1);
    bus.tx_enable = 1'b0;
    tests_run++;
    if (done_idx !== 45) begin
      tests_failed++;
      $display("FAIL x80_done_cycle: got %0d expected 45", done_idx);
    end
    tests_run++;
    if (shift_cnt !== 8) begin
      tests_failed++;
      $display("FAIL x80_shift_count: got %0d expected 8", shift_cnt);
    end
    for (int n = 0; n < 8; n++) begin
      for (int j = 0; j < CPB; j++) begin
        tests_run++;
        if (line_log[5 + 4*n + j] !== exp_bit[n]) begin
          tests_failed++;
          $display("FAIL x80_line bit%0d cyc%0d: got %b expected %b", n, j,
                   line_log[5 + 4*n + j], exp_bit[n]);
        end
      end
    end
    for (int c = 37; c <= 44; c++) begin
      tests_run++;
      if (line_log[c] !== LSE0) begin
        tests_failed++;
        $display("FAIL x80_se0[%0d]: got %b expected %b", c, line_log[c], LSE0);
      end
    end
    tests_run++;
    if (line_log[45] !== LJ) begin
      tests_failed++;
      $display("FAIL x80_eop_j: got %b expected %b", line_log[45], LJ);
    end
    tests_run++;
    if ({busy_log[0], busy_log[1], busy_log[44], busy_log[45]} !== 4'b0110) begin
      tests_failed++;
      $display("FAIL x80_busy: got %b expected 0110",
               {busy_log[0], busy_log[1], busy_log[44], busy_log[45]});
    end
    for (int c = 0; c <= 45; c++) begin
      exp_sh = (c >= 4) && (c <= 32) && (c % 4 == 0);
      tests_run++;
      if (shift_log[c] !== exp_sh) begin
        tests_failed++;
        $display("FAIL x80_shift_timing[%0d]: got %b expected %b", c, shift_log[c], exp_sh);
      end
    end
    @(negedge clk);
    tests_run++;
    if (bus.eop_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL x80_done_width: got %b expected 0", bus.eop_done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stuffing();
    logic [1:0] exp_p [17];
    logic       exp_sh;
    int         np;
    int         se0_at;
    int         done_at;
`ifdef USB_TX_BITSTUFF_EN
    exp_p   = '{LJ, LJ, LJ, LJ, LJ, LJ, LK, LK, LK, LJ, LK, LJ, LK, LJ, LK, LJ, LK};
    np      = 17;
    se0_at  = 73;
    done_at = 81;
`else
    exp_p   = '{LJ, LJ, LJ, LJ, LJ, LJ, LJ, LJ, LK, LJ, LK, LJ, LK, LJ, LK, LJ, LJ};
    np      = 16;
    se0_at  = 69;
    done_at = 77;
`endif
    run_packet(32'h0000_00FF, 16, 1'b1, -1);
    bus.tx_enable = 1'b0;
    tests_run++;
    if (done_idx !== done_at) begin
      tests_failed++;
      $display("FAIL stuff_done_cycle: got %0d expected %0d", done_idx, done_at);
    end
    tests_run++;
    if (shift_cnt !== 16) begin
      tests_failed++;
      $display("FAIL stuff_shift_count: got %0d expected 16", shift_cnt);
    end
    for (int p = 0; p < np; p++) begin
      for (int j = 0; j < CPB; j++) begin
        tests_run++;
        if (line_log[5 + 4*p + j] !== exp_p[p]) begin
          tests_failed++;
          $display("FAIL stuff_line period%0d cyc%0d: got %b expected %b", p, j,
                   line_log[5 + 4*p + j], exp_p[p]);
        end
      end
    end
    tests_run++;
    if (line_log[se0_at] !== LSE0) begin
      tests_failed++;
      $display("FAIL stuff_se0: got %b expected %b", line_log[se0_at], LSE0);
    end
    for (int c = 0; c <= done_at; c++) begin
`ifdef USB_TX_BITSTUFF_EN
      exp_sh = (c % 4 == 0) && (((c >= 4) && (c <= 24)) || ((c >= 32) && (c <= 68)));
`else
      exp_sh = (c % 4 == 0) && (c >= 4) && (c <= 64);
`endif
      tests_run++;
      if (shift_log[c] !== exp_sh) begin
        tests_failed++;
        $display("FAIL stuff_shift_timing[%0d]: got %b expected %b", c, shift_log[c], exp_sh);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    // Bits 0..2 = 0,1,1 -> K,K,K; leaves two ones counted when aborted.
    run_packet(32'h0000_0006, 8, 1'b0, 13);
    tests_run++;
    if ({line_log[14], busy_log[14]} !== {LK, 1'b1}) begin
      tests_failed++;
      $display("FAIL abort_before: got %b expected %b", {line_log[14], busy_log[14]}, {LK, 1'b1});
    end
    tests_run++;
    if ({line_log[15], busy_log[15], shift_log[15]} !== {LJ, 2'b00}) begin
      tests_failed++;
      $display("FAIL abort_after: got %b expected %b",
               {line_log[15], busy_log[15], shift_log[15]}, {LJ, 2'b00});
    end
    tests_run++;
    if (done_idx !== -1) begin
      tests_failed++;
      $display("FAIL abort_no_done: got %0d expected -1", done_idx);
    end
    tests_run++;
    if (shift_cnt !== 3) begin
      tests_failed++;
      $display("FAIL abort_shift_count: got %0d expected 3", shift_cnt);
    end
    tests_run++;
    if ({line_log[LOG_LEN-1], busy_log[LOG_LEN-1]} !== {LJ, 1'b0}) begin
      tests_failed++;
      $display("FAIL abort_stays_idle: got %b expected %b",
               {line_log[LOG_LEN-1], busy_log[LOG_LEN-1]}, {LJ, 1'b0});
    end
  endtask

  task automatic test_stuff_before_eop();
    int         done_at;
    logic [1:0] exp_29;
`ifdef USB_TX_BITSTUFF_EN
    done_at = 41;
    exp_29  = LK;
`else
    done_at = 37;
    exp_29  = LSE0;
`endif
    run_packet(32'h0000_003F, 6, 1'b1, -1);
    bus.tx_enable = 1'b0;
    tests_run++;
    if (done_idx !== done_at) begin
      tests_failed++;
      $display("FAIL six_ones_done_cycle: got %0d expected %0d", done_idx, done_at);
    end
    tests_run++;
    if (line_log[28] !== LJ) begin
      tests_failed++;
      $display("FAIL six_ones_last_bit: got %b expected %b", line_log[28], LJ);
    end
    tests_run++;
    if (line_log[29] !== exp_29) begin
      tests_failed++;
      $display("FAIL six_ones_after_bit5: got %b expected %b", line_log[29], exp_29);
    end
    tests_run++;
    if (line_log[done_at - 1] !== LSE0) begin
      tests_failed++;
      $display("FAIL six_ones_se0: got %b expected %b", line_log[done_at - 1], LSE0);
    end
    tests_run++;
    if (shift_cnt !== 6) begin
      tests_failed++;
      $display("FAIL six_ones_shift_count: got %0d expected 6", shift_cnt);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_enable_drop_in_eop();
    run_packet(32'h0000_0001, 1, 1'b1, 6);
    tests_run++;
    if (done_idx !== 17) begin
      tests_failed++;
      $display("FAIL eop_drop_done_cycle: got %0d expected 17", done_idx);
    end
    tests_run++;
    if ({line_log[10], line_log[16], line_log[17]} !== {LSE0, LSE0, LJ}) begin
      tests_failed++;
      $display("FAIL eop_drop_line: got %b expected %b",
               {line_log[10], line_log[16], line_log[17]}, {LSE0, LSE0, LJ});
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_packet(32'h0, 1, 1'b1, -1);
    tests_run++;
    if ({done_idx == 17, line_log[5], busy_log[17]} !== {1'b1, LK, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_first_packet: got done=%0d line=%b busy=%b expected done=17 line=%b busy=0",
               done_idx, line_log[5], busy_log[17], LK);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.tx_busy, bus.tx_shift, bus.d_plus, bus.d_minus} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL b2b_restart: got %b expected 1010",
               {bus.tx_busy, bus.tx_shift, bus.d_plus, bus.d_minus});
    end
    bus.tx_enable = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.tx_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_abort_idle: got %b expected 0", bus.tx_busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_eop();
    int seen_done = 0;
    @(posedge clk); #1;
    bus.tx_enable = 1'b1;
    bus.tx_out    = 1'b0;
    bus.eop_req   = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (bus.tx_shift !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_eop_first_shift: got %b expected 1", bus.tx_shift);
    end
    @(posedge clk); #1;
    bus.eop_req = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.d_plus, bus.d_minus, bus.tx_busy} !== {LK, 1'b1}) begin
      tests_failed++;
      $display("FAIL rst_eop_pre: got %b expected %b", {bus.d_plus, bus.d_minus, bus.tx_busy}, {LK, 1'b1});
    end
    #1;
    n_rst         = 1'b0;
    bus.tx_enable = 1'b0;
    #1;
    tests_run++;
    if ({bus.d_plus, bus.d_minus, bus.tx_shift, bus.tx_busy, bus.eop_done} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL rst_eop_immediate: got %b expected 10000",
               {bus.d_plus, bus.d_minus, bus.tx_shift, bus.tx_busy, bus.eop_done});
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 2) n_rst = 1'b1;
      if (bus.eop_done) seen_done++;
    end
    tests_run++;
    if (seen_done !== 0) begin
      tests_failed++;
      $display("FAIL rst_eop_no_done: got %0d expected 0", seen_done);
    end
    tests_run++;
    if ({bus.d_plus, bus.d_minus, bus.tx_busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL rst_eop_idle: got %b expected 100", {bus.d_plus, bus.d_minus, bus.tx_busy});
    end
  endtask

  initial begin
    test_reset();
    test_byte_0x80();
    test_stuffing();
    test_abort();
    test_stuff_before_eop();
    test_enable_drop_in_eop();
    test_back_to_back();
    test_reset_in_eop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
